pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised program-counter generator for the fetch stage; supersedes the plain PC register.
//  Adds fetch stall, prioritised trap/branch redirect, halt/resume and a return-address stack (RAS) for call/return prediction.
//  Sits between the branch/exception logic and the instruction memory address port.
// PARAMETERS
//  XLEN          32          address/data width of PC and targets
//  RESET_VECTOR  32'h0       PC value held from reset until first fetch
//  RAS_DEPTH     4           return-address stack entries (power of 2, >=2)
//  INSTR_BYTES   4           sequential increment (PC_Plus_4 = PC + INSTR_BYTES)
// PORTS
//  CLK              in   1     rising-edge clock
//  Reset_n          in   1     asynchronous, active-low reset
//  Stall            in   1     fetch not ready; hold PC and ignore Call_Push/Ret_Pop
//  Redirect_Valid   in   1     resolved branch/jump redirect
//  Redirect_Target  in   XLEN  redirect address
//  Trap             in   1     exception/interrupt entry
//  Trap_Vector      in   XLEN  trap handler address
//  Call_Push        in   1     current instruction is a call; push PC_Plus_4
//  Ret_Pop          in   1     current instruction is a return; predict from RAS top
//  Halt             in   1     request halt (debug/WFI)
//  Resume           in   1     leave HALTED
//  PC               out  XLEN  current fetch address
//  PC_Valid         out  1     PC is a valid fetch request this cycle
//  PC_Plus_4        out  XLEN  PC + INSTR_BYTES (combinational)
//  PC_Plus_8        out  XLEN  PC + 2*INSTR_BYTES (combinational)
//  Misaligned       out  1     1-cycle pulse: last accepted target had low bits set
//  Ras_Empty        out  1     RAS holds no entries
// BEHAVIOUR
//  Reset (Reset_n=0, async): PC=RESET_VECTOR, state=BOOT, PC_Valid=0, Misaligned=0, RAS count=0, Ras_Empty=1.
//  States: BOOT -> RUN next edge unconditionally (PC unchanged); RUN -> HALTED on Halt; HALTED -> RUN on Resume or Trap.
//  PC_Valid = (state==RUN). PC_Plus_4/PC_Plus_8 wrap modulo 2^XLEN.
//  Next-PC priority in RUN, evaluated per edge; new PC visible after that edge (latency 1):
//   1 Trap -> Trap_Vector; 2 Redirect_Valid -> Redirect_Target (both override Stall);
//   3 Stall -> hold PC; 4 Ret_Pop & !Ras_Empty -> RAS top; 5 else PC_Plus_4.
//  Ret_Pop with Ras_Empty -> PC_Plus_4, no RAS change.
//  Targets from Trap/Redirect: low log2(INSTR_BYTES) bits cleared; Misaligned=1 for one cycle if they were nonzero.
//  RAS updates only when RUN & !Stall & !Trap & !Redirect_Valid:
//   push only -> write PC_Plus_4 at top, count++ (saturates at RAS_DEPTH; at full, oldest entry overwritten, circular pointer);
//   pop only (non-empty) -> count--; push+pop same cycle -> next PC = old top, top replaced by PC_Plus_4, count unchanged.
//  Trap/Redirect do not flush the RAS.
//  Halt in RUN: PC not advanced on that edge; Halt and Trap together -> Trap wins, stay RUN.
//  HALTED: PC held, PC_Valid=0; Redirect_Valid updates PC but stays HALTED;
//   Trap -> PC=Trap_Vector, RUN; Resume -> RUN at held PC; Halt and Resume together -> stay HALTED.
//  Reset asserted mid-operation: all state returns to reset values immediately; pending events dropped.
// STRUCTURE
//  Package pc_pkg: state enum {BOOT, RUN, HALTED}, next-PC select codes, alignment-mask helper.
//  Sub-module return_address_stack (RAS_DEPTH, XLEN): push/pop/top/empty/full, circular pointer, saturating count.
//  Top level: state FSM, next-PC priority mux, PC register, Misaligned register.
// TESTING
//  Reset_n low, release -> PC=0, PC_Valid=0 for 1 cycle, then PC 0,4,8,... with PC_Valid=1.
//  At PC=0x10: Redirect_Valid=1, Redirect_Target=0x100, Stall=1 -> next PC=0x100; Stall then holds at 0x100.
//  Trap=1 (Trap_Vector=0x80) and Redirect_Valid=1 (Redirect_Target=0x200) same cycle -> PC=0x80.
//  Call_Push at 0x20 and 0x40; Ret_Pop at 0x300 -> PC=0x44; Ret_Pop again -> PC=0x24; third pop -> 0x28 (Ras_Empty).
//  RAS_DEPTH=4: 5 pushes then 5 pops -> 4 predicted targets newest-first, 5th pop falls through to PC_Plus_4.
//  Redirect_Target=0x102 -> PC=0x100, Misaligned pulses 1 cycle; Halt -> PC_Valid=0, PC held; Resume -> continues.
//  Reset_n asserted while HALTED with RAS full -> PC=RESET_VECTOR, Ras_Empty=1 asynchronously.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD     = 3'd0,
    SEL_SEQ      = 3'd1,
    SEL_RAS      = 3'd2,
    SEL_TRAP     = 3'd3,
    SEL_REDIRECT = 3'd4
  } pc_sel_t;

  // Mask that clears the sub-instruction offset bits of an address.
  function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
    return ~(64'(instr_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack with a saturating occupancy count;
// pushing while full silently overwrites the oldest entry.
module return_address_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_up;
  logic [CW-1:0]   count;

  assign ptr_up = ptr + PW'(1);
  assign top    = mem[ptr];
  assign empty  = (count == CW'(0));

  // Stack pointer, occupancy and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem[i] <= '0;
      end
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr] <= push_data;
    end else if (push) begin
      mem[ptr_up] <= push_data;
      ptr         <= ptr_up;
      if (count != CW'(RAS_DEPTH)) begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: boot/run/halt FSM, prioritised trap/redirect
// steering, stall hold and return-address-stack prediction.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              INSTR_BYTES  = 4
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic            Stall,
  input  logic            Redirect_Valid,
  input  logic [XLEN-1:0] Redirect_Target,
  input  logic            Trap,
  input  logic [XLEN-1:0] Trap_Vector,
  input  logic            Call_Push,
  input  logic            Ret_Pop,
  input  logic            Halt,
  input  logic            Resume,
  output logic [XLEN-1:0] PC,
  output logic            PC_Valid,
  output logic [XLEN-1:0] PC_Plus_4,
  output logic [XLEN-1:0] PC_Plus_8,
  output logic            Misaligned,
  output logic            Ras_Empty
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] STEP2      = XLEN'(2 * INSTR_BYTES);
  localparam logic [63:0]     ALIGN_WIDE = align_mask(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ALIGN_WIDE[XLEN-1:0];

  fetch_state_t    state;
  pc_sel_t         sel;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            target_taken;

  assign PC_Plus_4    = PC + STEP;
  assign PC_Plus_8    = PC + STEP2;
  assign PC_Valid     = (state == RUN);
  assign target_taken = (sel == SEL_TRAP) || (sel == SEL_REDIRECT);

  return_address_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst_n     (Reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (PC_Plus_4),
    .top       (ras_top),
    .empty     (Ras_Empty)
  );

  // Next-PC source selection and RAS update enables.
  // A halting instruction is not issued, so it neither advances the PC nor touches the RAS.
  always_comb begin
    sel        = SEL_HOLD;
    raw_target = Redirect_Target;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    case (state)
      RUN: begin
        if (Trap) begin
          sel        = SEL_TRAP;
          raw_target = Trap_Vector;
        end else if (Redirect_Valid) begin
          sel = SEL_REDIRECT;
        end else if (Stall || Halt) begin
          sel = SEL_HOLD;
        end else if (Ret_Pop && !Ras_Empty) begin
          sel      = SEL_RAS;
          ras_pop  = 1'b1;
          ras_push = Call_Push;
        end else begin
          sel      = SEL_SEQ;
          ras_push = Call_Push;
        end
      end
      HALTED: begin
        if (Trap) begin
          sel        = SEL_TRAP;
          raw_target = Trap_Vector;
        end else if (Redirect_Valid) begin
          sel = SEL_REDIRECT;
        end else begin
          sel = SEL_HOLD;
        end
      end
      default: sel = SEL_HOLD;
    endcase
  end

  // Next-PC value for the selected source.
  always_comb begin
    next_pc = PC;
    case (sel)
      SEL_TRAP, SEL_REDIRECT: next_pc = raw_target & ALIGN_MASK;
      SEL_RAS:                next_pc = ras_top;
      SEL_SEQ:                next_pc = PC_Plus_4;
      default:                next_pc = PC;
    endcase
  end

  // State FSM, PC register and misalignment pulse.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= BOOT;
      PC         <= RESET_VECTOR;
      Misaligned <= 1'b0;
    end else begin
      PC         <= next_pc;
      Misaligned <= target_taken && ((raw_target & ~ALIGN_MASK) != '0);
      case (state)
        BOOT:    state <= RUN;
        RUN:     state <= (!Trap && Halt) ? HALTED : RUN;
        HALTED:  state <= (Trap || (Resume && !Halt)) ? RUN : HALTED;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised and directed bench for pc_fetch_unit against a queue-based behavioural model.
module tb_pc_fetch_unit;

  localparam int M_BOOT = 0, M_RUN = 1, M_HALTED = 2;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset_n, Stall, Redirect_Valid, Trap, Call_Push, Ret_Pop, Halt, Resume;
  logic [31:0] Redirect_Target, Trap_Vector;
  logic [31:0] PC, PC_Plus_4, PC_Plus_8;
  logic        PC_Valid, Misaligned, Ras_Empty;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] m_pc;
  int          m_mode;
  logic        m_mis;
  logic [31:0] ras[$];

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Stall(Stall), .Redirect_Valid(Redirect_Valid),
    .Redirect_Target(Redirect_Target), .Trap(Trap), .Trap_Vector(Trap_Vector),
    .Call_Push(Call_Push), .Ret_Pop(Ret_Pop), .Halt(Halt), .Resume(Resume),
    .PC(PC), .PC_Valid(PC_Valid), .PC_Plus_4(PC_Plus_4), .PC_Plus_8(PC_Plus_8),
    .Misaligned(Misaligned), .Ras_Empty(Ras_Empty)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic idle();
    Stall = 0; Redirect_Valid = 0; Trap = 0; Call_Push = 0; Ret_Pop = 0;
    Halt = 0; Resume = 0; Redirect_Target = 32'h0; Trap_Vector = 32'h0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_mode = M_BOOT; m_mis = 1'b0; ras.delete();
  endtask

  task automatic take(input logic [31:0] t);
    m_pc  = t & ~32'd3;
    m_mis = (t[1:0] != 2'b00);
  endtask

  // Architectural effect of one clock edge given the current inputs.
  task automatic model_step();
    logic [31:0] p4;
    p4    = m_pc + 32'd4;
    m_mis = 1'b0;
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (Trap) take(Trap_Vector);
      else begin
        if (Redirect_Valid) take(Redirect_Target);
        else if (!Stall && !Halt) begin
          if (Ret_Pop && ras.size() > 0) begin
            m_pc = ras.pop_back();
            if (Call_Push) ras.push_back(p4);
          end else begin
            m_pc = p4;
            if (Call_Push) begin
              if (ras.size() == DEPTH) void'(ras.pop_front());
              ras.push_back(p4);
            end
          end
        end
        if (Halt) m_mode = M_HALTED;
      end
    end else begin
      if (Trap) begin
        take(Trap_Vector);
        m_mode = M_RUN;
      end else begin
        if (Redirect_Valid) take(Redirect_Target);
        if (Resume && !Halt) m_mode = M_RUN;
      end
    end
  endtask

  // One clock: advance the model, let the DUT take the edge, compare on the falling edge.
  task automatic cycle();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    chk("pc",         PC,               m_pc);
    chk("pc_valid",   {31'b0, PC_Valid}, {31'b0, (m_mode == M_RUN)});
    chk("pc_plus_4",  PC_Plus_4,        m_pc + 32'd4);
    chk("pc_plus_8",  PC_Plus_8,        m_pc + 32'd8);
    chk("misaligned", {31'b0, Misaligned}, {31'b0, m_mis});
    chk("ras_empty",  {31'b0, Ras_Empty},  {31'b0, (ras.size() == 0)});
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    model_reset();
    #12;
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'b0, PC_Valid}, 32'd0);
    chk("rst_mis", {31'b0, Misaligned}, 32'd0);
    chk("rst_ras_empty", {31'b0, Ras_Empty}, 32'd1);
    @(negedge CLK);
    Reset_n = 1'b1;

    // Boot then sequential fetch.
    cycle(); chk("boot_pc0", PC, 32'h0); chk("boot_valid", {31'b0, PC_Valid}, 32'd1);
    cycle(); chk("seq_pc4", PC, 32'h4);
    cycle(); chk("seq_pc8", PC, 32'h8);
    cycle(); cycle(); chk("seq_pc10", PC, 32'h10);

    // Redirect overrides stall; stall then holds.
    Redirect_Valid = 1; Redirect_Target = 32'h100; Stall = 1;
    cycle(); chk("redir_over_stall", PC, 32'h100);
    Redirect_Valid = 0;
    cycle(); chk("stall_hold", PC, 32'h100);
    Stall = 0;

    // Trap beats redirect.
    Trap = 1; Trap_Vector = 32'h80; Redirect_Valid = 1; Redirect_Target = 32'h200;
    cycle(); chk("trap_prio", PC, 32'h80);
    idle();

    // Call/return prediction.
    Redirect_Valid = 1; Redirect_Target = 32'h20; cycle(); idle();
    Call_Push = 1; cycle(); idle();
    Redirect_Valid = 1; Redirect_Target = 32'h40; cycle(); idle();
    Call_Push = 1; cycle(); idle();
    Redirect_Valid = 1; Redirect_Target = 32'h300; cycle(); idle();
    Ret_Pop = 1;
    cycle(); chk("ret1", PC, 32'h44);
    cycle(); chk("ret2", PC, 32'h24);
    cycle(); chk("ret3_fallthru", PC, 32'h28);
    chk("ret3_empty", {31'b0, Ras_Empty}, 32'd1);
    idle();

    // Overflow: five pushes, five pops.
    Call_Push = 1;
    for (int i = 0; i < 5; i++) cycle();
    chk("ovf_pc", PC, 32'h3C);
    idle(); Ret_Pop = 1;
    cycle(); chk("ovf_pop1", PC, 32'h3C);
    cycle(); chk("ovf_pop2", PC, 32'h38);
    cycle(); chk("ovf_pop3", PC, 32'h34);
    cycle(); chk("ovf_pop4", PC, 32'h30);
    chk("ovf_empty", {31'b0, Ras_Empty}, 32'd1);
    cycle(); chk("ovf_pop5", PC, 32'h34);
    idle();

    // Misaligned target, halt and resume.
    Redirect_Valid = 1; Redirect_Target = 32'h102;
    cycle(); chk("mis_pc", PC, 32'h100); chk("mis_pulse", {31'b0, Misaligned}, 32'd1);
    idle();
    cycle(); chk("mis_clear", {31'b0, Misaligned}, 32'd0); chk("after_mis", PC, 32'h104);
    Halt = 1;
    cycle(); chk("halt_pc", PC, 32'h104); chk("halt_valid", {31'b0, PC_Valid}, 32'd0);
    Halt = 0;
    cycle(); chk("halted_hold", PC, 32'h104);
    Resume = 1;
    cycle(); chk("resume_valid", {31'b0, PC_Valid}, 32'd1);
    Resume = 0;
    cycle(); chk("resume_pc", PC, 32'h108);

    // Asynchronous reset while halted with a full RAS.
    Call_Push = 1;
    for (int i = 0; i < 4; i++) cycle();
    idle(); Halt = 1; cycle(); idle();
    chk("full_not_empty", {31'b0, Ras_Empty}, 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_pc", PC, 32'h0);
    chk("async_rst_empty", {31'b0, Ras_Empty}, 32'd1);
    chk("async_rst_valid", {31'b0, PC_Valid}, 32'd0);
    model_reset();
    @(negedge CLK);
    Reset_n = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      Stall           = ($urandom_range(0, 99) < 20);
      Redirect_Valid  = ($urandom_range(0, 99) < 8);
      Trap            = ($urandom_range(0, 99) < 4);
      Call_Push       = ($urandom_range(0, 99) < 30);
      Ret_Pop         = ($urandom_range(0, 99) < 30);
      Halt            = ($urandom_range(0, 99) < 5);
      Resume          = ($urandom_range(0, 99) < 30);
      Redirect_Target = $urandom();
      Trap_Vector     = $urandom();
      if ($urandom_range(0, 1) == 0) Redirect_Target[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) Trap_Vector[1:0] = 2'b00;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
